uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: first-word-fall-through byte queue
// with a per-entry parity-error tag, occupancy flags and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid_in,
    input  logic [7:0]                 rx_data_in,
    input  logic                       rx_parity_ok_in,
    input  logic                       rd_en,
    input  logic                       overrun_clr,
    output logic [7:0]                 rd_data,
    output logic                       rd_parity_err,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    // {parity_err, data}; storage needs no reset since count gates visibility
    logic [8:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overrun_reg, overrun_next;

    logic          do_write;
    logic          do_read;
    logic          overrun_evt;
    logic [8:0]    head_entry;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_CNT);
    assign almost_full = (count_reg >= AF_CNT);
    assign count       = count_reg;
    assign overrun     = overrun_reg;

    // A full queue still accepts a byte when the consumer pops on the same edge
    assign do_read     = rd_en && !empty;
    assign do_write    = rx_valid_in && (!full || rd_en);
    assign overrun_evt = rx_valid_in && full && !rd_en;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_write) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (do_read) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (do_write && !do_read) begin
            count_next = count_reg + CW'(1);
        end else if (do_read && !do_write) begin
            count_next = count_reg - CW'(1);
        end
    end

    // A fresh overrun outranks a coincident clear so no drop goes unreported
    always_comb begin
        overrun_next = overrun_reg;
        if (overrun_evt) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= {~rx_parity_ok_in, rx_data_in};
        end
    end

    assign head_entry = mem[rd_ptr_reg];

    always_comb begin
        rd_data       = 8'h00;
        rd_parity_err = 1'b0;
        if (!empty) begin
            rd_data       = head_entry[7:0];
            rd_parity_err = head_entry[8];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, AF_LEVEL=12).
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx_valid_in;
    logic [7:0] rx_data_in;
    logic       rx_parity_ok_in;
    logic       rd_en;
    logic       overrun_clr;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overrun;

    int checks;
    int failures;

    uart_rx_fifo #(.DEPTH(16), .AF_LEVEL(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid_in    (rx_valid_in),
        .rx_data_in     (rx_data_in),
        .rx_parity_ok_in(rx_parity_ok_in),
        .rd_en          (rd_en),
        .overrun_clr    (overrun_clr),
        .rd_data        (rd_data),
        .rd_parity_err  (rd_parity_err),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .count          (count),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one clock of stimulus; returns 1 time unit after the edge
    task automatic cycle(input logic v, input logic [7:0] d, input logic pok,
                         input logic rd, input logic clr);
        rx_valid_in     = v;
        rx_data_in      = d;
        rx_parity_ok_in = pok;
        rd_en           = rd;
        overrun_clr     = clr;
        @(posedge clk);
        #1;
        rx_valid_in = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pok);
        cycle(1'b1, d, pok, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, rd_data}, {24'h0, exp});
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        rx_valid_in     = 1'b0;
        rx_data_in      = 8'h00;
        rx_parity_ok_in = 1'b1;
        rd_en           = 1'b0;
        overrun_clr     = 1'b0;

        #3;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_perr", 32'(rd_parity_err), 32'd0);
        #19 reset = 1'b1;

        // single byte, accepted on first edge after reset release
        push(8'hA5, 1'b1);
        chk("a5_empty", 32'(empty), 32'd0);
        chk("a5_count", 32'(count), 32'd1);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_perr", 32'(rd_parity_err), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("a5_pop_empty", 32'(empty), 32'd1);
        chk("a5_pop_data", 32'(rd_data), 32'd0);

        // fill/drain three times to wrap pointers
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 16; i++) begin
                push(8'(i), 1'b1);
                chk($sformatf("fill%0d_af%0d", rep, i), 32'(almost_full), 32'(i + 1 >= 12));
                chk($sformatf("fill%0d_cnt%0d", rep, i), 32'(count), 32'(i + 1));
            end
            chk($sformatf("fill%0d_full", rep), 32'(full), 32'd1);
            for (int i = 0; i < 16; i++) begin
                pop_expect($sformatf("drain%0d_%0d", rep, i), 8'(i));
            end
            chk($sformatf("drain%0d_empty", rep), 32'(empty), 32'd1);
            chk($sformatf("drain%0d_full", rep), 32'(full), 32'd0);
        end

        // overrun on a full queue
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
        push(8'h77, 1'b1);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_count", 32'(count), 32'd16);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("ovr_clr", 32'(overrun), 32'd0);

        // simultaneous push/pop while full
        cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("fullrw_count", 32'(count), 32'd16);
        chk("fullrw_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_expect($sformatf("fullrw_pop%0d", i), 8'(8'h10 + i));
        pop_expect("fullrw_last55", 8'h55);
        chk("fullrw_empty", 32'(empty), 32'd1);

        // parity error tag, then pop on empty
        push(8'h3C, 1'b0);
        chk("perr_flag", 32'(rd_parity_err), 32'd1);
        chk("perr_data", 32'(rd_data), 32'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rd_empty_count", 32'(count), 32'd0);
        chk("rd_empty_empty", 32'(empty), 32'd1);

        // simultaneous push/pop at count=1
        push(8'h01, 1'b1);
        cycle(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
        chk("c1rw_count", 32'(count), 32'd1);
        chk("c1rw_data", 32'(rd_data), 32'h02);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // asynchronous reset mid-cycle with five entries
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b1);
        chk("pre_arst_count", 32'(count), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_data", 32'(rd_data), 32'd0);
        #2 reset = 1'b1;

        // clear coincident with a new overrun keeps the flag
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b1);
        cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_ovr", 32'(overrun), 32'd1);
        chk("clr_vs_ovr_cnt", 32'(count), 32'd16);
        chk("clr_vs_ovr_head", 32'(rd_data), 32'h60);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("clr_after", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
